// File: rtl/circle_gen.sv
// circle_gen: midpoint-circle rasteriser. Emits one registered pixel candidate per clock,
// either the 8-way outline or left-to-right horizontal spans of a filled disc.
//   state  | meaning
//   S_IDLE | waiting for start; inputs latched on accept
//   S_DRAW | stepping candidates; r_fin marks the final candidate has been emitted
//   S_DONE | done high until start falls
module circle_gen #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int R_W      = 8,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                fill,
  input  logic [COLOUR_W-1:0] colour,
  input  logic [X_W-1:0]      centre_x,
  input  logic [Y_W-1:0]      centre_y,
  input  logic [R_W-1:0]      radius,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);
  localparam int CW = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam int OW = R_W + 3;
  localparam logic signed [OW-1:0] O_ONE = OW'(1);
  localparam logic signed [CW-1:0] C_ONE = CW'(1);
  localparam logic signed [CW-1:0] C_SW  = CW'(SCREEN_W);
  localparam logic signed [CW-1:0] C_SH  = CW'(SCREEN_H);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  state_t                r_state, w_state_n;
  logic [X_W-1:0]        r_cx;
  logic [Y_W-1:0]        r_cy;
  logic [COLOUR_W-1:0]   r_colour;
  logic                  r_fill;
  logic signed [OW-1:0]  r_ox, r_oy, r_crit;
  logic [2:0]            r_step;
  logic [1:0]            r_span;
  logic signed [CW-1:0]  r_sx;
  logic                  r_fin;

  logic signed [CW-1:0]  w_cx, w_cy, w_ox, w_oy, w_x, w_y, w_xend;
  logic signed [OW-1:0]  w_ox_n, w_oy_n, w_crit_n;
  logic                  w_iter_end, w_emit, w_inb;
  logic                  w_busy_n, w_done_n, w_plot_n;
  logic [X_W-1:0]        w_vx_n;
  logic [Y_W-1:0]        w_vy_n;
  logic [COLOUR_W-1:0]   w_col_n;

  assign w_cx = $signed(CW'(r_cx));
  assign w_cy = $signed(CW'(r_cy));
  assign w_ox = CW'(r_ox);
  assign w_oy = CW'(r_oy);

  // Current candidate, plus the right-hand end of the active span in fill mode.
  always_comb begin
    w_x    = '0;
    w_y    = '0;
    w_xend = '0;
    if (!r_fill) begin
      case (r_step)
        3'd0: begin w_x = w_cx + w_ox; w_y = w_cy + w_oy; end
        3'd1: begin w_x = w_cx + w_oy; w_y = w_cy + w_ox; end
        3'd2: begin w_x = w_cx - w_oy; w_y = w_cy + w_ox; end
        3'd3: begin w_x = w_cx - w_ox; w_y = w_cy + w_oy; end
        3'd4: begin w_x = w_cx - w_ox; w_y = w_cy - w_oy; end
        3'd5: begin w_x = w_cx - w_oy; w_y = w_cy - w_ox; end
        3'd6: begin w_x = w_cx + w_oy; w_y = w_cy - w_ox; end
        default: begin w_x = w_cx + w_ox; w_y = w_cy - w_oy; end
      endcase
    end else begin
      w_x = r_sx;
      case (r_span)
        2'd0: begin w_y = w_cy + w_oy; w_xend = w_cx + w_ox; end
        2'd1: begin w_y = w_cy - w_oy; w_xend = w_cx + w_ox; end
        2'd2: begin w_y = w_cy + w_ox; w_xend = w_cx + w_oy; end
        default: begin w_y = w_cy - w_ox; w_xend = w_cx + w_oy; end
      endcase
    end
  end

  always_comb begin
    w_oy_n = r_oy + O_ONE;
    if (r_crit <= 0) begin
      w_ox_n   = r_ox;
      w_crit_n = r_crit + (w_oy_n <<< 1) + O_ONE;
    end else begin
      w_ox_n   = r_ox - O_ONE;
      w_crit_n = r_crit + ((w_oy_n - w_ox_n) <<< 1) + O_ONE;
    end
  end

  assign w_iter_end = r_fill ? ((r_span == 2'd3) && (r_sx == w_xend)) : (r_step == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_n = S_DRAW;
      S_DRAW:  if (r_fin)  w_state_n = S_DONE;
      S_DONE:  if (!start) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_comb begin
    w_emit   = (r_state == S_DRAW) && !r_fin;
    w_inb    = (w_x >= 0) && (w_x < C_SW) && (w_y >= 0) && (w_y < C_SH);
    w_busy_n = (w_state_n == S_DRAW);
    w_done_n = (w_state_n == S_DONE);
    w_plot_n = w_emit && w_inb;
    w_vx_n   = w_emit ? w_x[X_W-1:0] : '0;
    w_vy_n   = w_emit ? w_y[Y_W-1:0] : '0;
    w_col_n  = w_emit ? r_colour : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      busy       <= w_busy_n;
      done       <= w_done_n;
      vga_x      <= w_vx_n;
      vga_y      <= w_vy_n;
      vga_colour <= w_col_n;
      vga_plot   <= w_plot_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cx     <= '0;
      r_cy     <= '0;
      r_colour <= '0;
      r_fill   <= 1'b0;
      r_ox     <= '0;
      r_oy     <= '0;
      r_crit   <= '0;
      r_step   <= '0;
      r_span   <= '0;
      r_sx     <= '0;
      r_fin    <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (start) begin
        r_cx     <= centre_x;
        r_cy     <= centre_y;
        r_colour <= colour;
        r_fill   <= fill;
        r_ox     <= $signed(OW'(radius));
        r_oy     <= '0;
        r_crit   <= O_ONE - $signed(OW'(radius));
        r_step   <= '0;
        r_span   <= '0;
        r_sx     <= $signed(CW'(centre_x)) - $signed(CW'(radius));
        r_fin    <= 1'b0;
      end
    end else if ((r_state == S_DRAW) && !r_fin) begin
      if (w_iter_end) begin
        r_ox   <= w_ox_n;
        r_oy   <= w_oy_n;
        r_crit <= w_crit_n;
        r_step <= '0;
        r_span <= '0;
        r_sx   <= w_cx - CW'(w_ox_n);
        r_fin  <= (w_oy_n > w_ox_n);
      end else if (!r_fill) begin
        r_step <= r_step + 3'd1;
      end else if (r_sx == w_xend) begin
        // Span B reuses the ox range; spans C and D use oy.
        r_span <= r_span + 2'd1;
        r_sx   <= (r_span == 2'd0) ? (w_cx - w_ox) : (w_cx - w_oy);
      end else begin
        r_sx <= r_sx + C_ONE;
      end
    end
  end

endmodule

// File: tb/tb_circle_gen.sv
// Bench for circle_gen: directed and random draws compared cycle by cycle against
// a candidate list built from the midpoint-circle rules with plain integers.
module tb_circle_gen;
  localparam int SW = 160;
  localparam int SH = 120;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int RW = 8;
  localparam int CLW = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           fill = 1'b0;
  logic [CLW-1:0] colour = '0;
  logic [XW-1:0]  centre_x = '0;
  logic [YW-1:0]  centre_y = '0;
  logic [RW-1:0]  radius = '0;
  logic           busy, done, vga_plot;
  logic [XW-1:0]  vga_x;
  logic [YW-1:0]  vga_y;
  logic [CLW-1:0] vga_colour;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {int x; int y;} cand_t;
  cand_t exp_q[$];

  circle_gen #(.SCREEN_W(SW), .SCREEN_H(SH), .X_W(XW), .Y_W(YW), .R_W(RW), .COLOUR_W(CLW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fill(fill), .colour(colour),
    .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
    .busy(busy), .done(done), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_c(input int x, input int y);
    cand_t c;
    c.x = x;
    c.y = y;
    exp_q.push_back(c);
  endtask

  task automatic build_model(input int cx, input int cy, input int r, input bit f);
    int ox, oy, crit;
    exp_q.delete();
    ox = r; oy = 0; crit = 1 - r;
    while (oy <= ox) begin
      if (!f) begin
        push_c(cx+ox, cy+oy); push_c(cx+oy, cy+ox);
        push_c(cx-oy, cy+ox); push_c(cx-ox, cy+oy);
        push_c(cx-ox, cy-oy); push_c(cx-oy, cy-ox);
        push_c(cx+oy, cy-ox); push_c(cx+ox, cy-oy);
      end else begin
        for (int x = cx-ox; x <= cx+ox; x++) push_c(x, cy+oy);
        for (int x = cx-ox; x <= cx+ox; x++) push_c(x, cy-oy);
        for (int x = cx-oy; x <= cx+oy; x++) push_c(x, cy+ox);
        for (int x = cx-oy; x <= cx+oy; x++) push_c(x, cy-ox);
      end
      oy = oy + 1;
      if (crit <= 0) crit = crit + 2*oy + 1;
      else begin
        ox = ox - 1;
        crit = crit + 2*(oy - ox) + 1;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_x"}, vga_x, 0);
    check_val({tag, "_y"}, vga_y, 0);
    check_val({tag, "_col"}, vga_colour, 0);
    check_val({tag, "_plot"}, vga_plot, 0);
  endtask

  // hold: extra cycles start stays high in DONE; drop: release start right after accept
  task automatic run_draw(input int cx, input int cy, input int r, input bit f,
                          input int col, input int hold, input bit drop);
    int ex, ey, ep;
    build_model(cx, cy, r, f);
    @(negedge clk);
    centre_x = cx[XW-1:0]; centre_y = cy[YW-1:0]; radius = r[RW-1:0];
    fill = f; colour = col[CLW-1:0]; start = 1'b1;
    @(posedge clk); #1;
    check_val("accept_busy", busy, 1);
    check_val("accept_plot", vga_plot, 0);
    @(negedge clk);
    centre_x = XW'($urandom); centre_y = YW'($urandom); radius = RW'($urandom);
    fill = ~f; colour = CLW'($urandom);
    if (drop) start = 1'b0;
    foreach (exp_q[i]) begin
      @(posedge clk); #1;
      ex = exp_q[i].x; ey = exp_q[i].y;
      ep = (ex >= 0 && ex < SW && ey >= 0 && ey < SH) ? 1 : 0;
      check_val("cand_x", vga_x, ex & ((1 << XW) - 1));
      check_val("cand_y", vga_y, ey & ((1 << YW) - 1));
      check_val("cand_plot", vga_plot, ep);
      check_val("cand_colour", vga_colour, col);
      check_val("cand_busy", busy, 1);
      check_val("cand_done", done, 0);
    end
    @(posedge clk); #1;
    check_val("end_done", done, 1);
    check_val("end_busy", busy, 0);
    check_val("end_plot", vga_plot, 0);
    if (!drop) begin
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        check_val("hold_done", done, 1);
        check_val("hold_plot", vga_plot, 0);
      end
      @(negedge clk);
      start = 1'b0;
    end
    @(posedge clk); #1;
    check_val("release_done", done, 0);
    check_val("release_busy", busy, 0);
  endtask

  initial begin
    int cx, cy, r, col, hold;
    bit f, drop;
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_draw(80, 60, 1, 1'b0, 5, 2, 1'b0);
    run_draw(0, 0, 0, 1'b0, 3, 3, 1'b0);
    run_draw(10, 10, 2, 1'b1, 6, 1, 1'b0);
    run_draw(0, 0, 5, 1'b0, 7, 0, 1'b1);
    run_draw(0, 0, 255, 1'b0, 1, 0, 1'b0);
    run_draw(10, 10, 0, 1'b1, 2, 1, 1'b0);
    run_draw(159, 119, 3, 1'b1, 4, 0, 1'b1);

    for (int n = 0; n < 8; n++) begin
      f    = 1'($urandom_range(0, 1));
      r    = f ? $urandom_range(0, 20) : $urandom_range(0, 255);
      cx   = $urandom_range(0, 255);
      cy   = $urandom_range(0, 127);
      col  = $urandom_range(0, 7);
      hold = $urandom_range(0, 3);
      drop = 1'($urandom_range(0, 1));
      run_draw(cx, cy, r, f, col, hold, drop);
    end

    // Reset in the middle of a fill draw
    @(negedge clk);
    centre_x = 8'd50; centre_y = 7'd50; radius = 8'd10; fill = 1'b1; colour = 3'd5; start = 1'b1;
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_val("post_reset_plot", vga_plot, 0);
      check_val("post_reset_busy", busy, 0);
    end
    run_draw(80, 60, 1, 1'b0, 5, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
